// File: rtl/noc_credit_link.sv
// Credit-based pipelined inter-router link: forward flit slices, backward credit
// slices, upstream credit counters, a link-enable gate and sticky protocol errors.
module noc_credit_link #(
    parameter int FLIT_WIDTH   = 64,
    parameter int VC_NUM       = 2,
    parameter int LINK_STAGES  = 1,
    parameter int CREDIT_DEPTH = 4,
    parameter int VCW          = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
    parameter int CW           = $clog2(CREDIT_DEPTH + 1)
) (
    input  logic                   noc_clk,
    input  logic                   noc_rst,
    input  logic                   link_en,
    input  logic                   in_valid,
    input  logic [VCW-1:0]         in_vc,
    input  logic [FLIT_WIDTH-1:0]  in_flit,
    output logic [VC_NUM-1:0]      in_vc_ready,
    output logic                   out_valid,
    output logic [VCW-1:0]         out_vc,
    output logic [FLIT_WIDTH-1:0]  out_flit,
    input  logic [VC_NUM-1:0]      out_credit,
    output logic [VC_NUM*CW-1:0]   credit_cnt,
    output logic                   err_overflow,
    output logic                   err_credit
);

    logic [CW-1:0]     cnt [VC_NUM];
    logic [VC_NUM-1:0] send;
    logic [VC_NUM-1:0] cred_ret;
    logic              accept;

    // An out-of-range in_vc matches no counter, so it is never accepted.
    always_comb begin
        send = '0;
        for (int v = 0; v < VC_NUM; v++) begin
            send[v] = in_valid && link_en && (in_vc == VCW'(v)) && (cnt[v] != '0);
        end
    end

    assign accept = |send;

    for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
        assign in_vc_ready[v]            = link_en && (cnt[v] != '0);
        assign credit_cnt[v*CW +: CW]    = cnt[v];
    end

    always_ff @(posedge noc_clk) begin
        if (noc_rst) begin
            for (int v = 0; v < VC_NUM; v++) begin
                cnt[v] <= CW'(CREDIT_DEPTH);
            end
            err_overflow <= 1'b0;
            err_credit   <= 1'b0;
        end else begin
            if (in_valid && !accept) begin
                err_overflow <= 1'b1;
            end
            for (int v = 0; v < VC_NUM; v++) begin
                if (send[v] && !cred_ret[v]) begin
                    cnt[v] <= cnt[v] - CW'(1);
                end else if (!send[v] && cred_ret[v]) begin
                    // Saturate rather than wrap; a surplus credit is a downstream bug.
                    if (cnt[v] == CW'(CREDIT_DEPTH)) begin
                        err_credit <= 1'b1;
                    end else begin
                        cnt[v] <= cnt[v] + CW'(1);
                    end
                end
            end
        end
    end

    if (LINK_STAGES == 0) begin : g_comb
        assign out_valid = accept;
        assign out_vc    = accept ? in_vc : '0;
        assign out_flit  = accept ? in_flit : '0;
        assign cred_ret  = out_credit;
    end else begin : g_pipe
        logic                  v_q [LINK_STAGES];
        logic [VCW-1:0]        vc_q [LINK_STAGES];
        logic [FLIT_WIDTH-1:0] f_q [LINK_STAGES];
        logic [VC_NUM-1:0]     c_q [LINK_STAGES];

        // Payload slices load only behind a valid, so idle cycles hold old data.
        always_ff @(posedge noc_clk) begin
            if (noc_rst) begin
                for (int s = 0; s < LINK_STAGES; s++) begin
                    v_q[s]  <= 1'b0;
                    vc_q[s] <= '0;
                    f_q[s]  <= '0;
                    c_q[s]  <= '0;
                end
            end else begin
                v_q[0] <= accept;
                c_q[0] <= out_credit;
                if (accept) begin
                    vc_q[0] <= in_vc;
                    f_q[0]  <= in_flit;
                end
                for (int s = 1; s < LINK_STAGES; s++) begin
                    v_q[s] <= v_q[s-1];
                    c_q[s] <= c_q[s-1];
                    if (v_q[s-1]) begin
                        vc_q[s] <= vc_q[s-1];
                        f_q[s]  <= f_q[s-1];
                    end
                end
            end
        end

        assign out_valid = v_q[LINK_STAGES-1];
        assign out_vc    = vc_q[LINK_STAGES-1];
        assign out_flit  = f_q[LINK_STAGES-1];
        assign cred_ret  = c_q[LINK_STAGES-1];
    end

endmodule

// File: tb/tb_noc_credit_link.sv
// Bench for noc_credit_link: a two-stage link checked through a flit scoreboard,
// plus a zero-stage, single-credit link checked cycle by cycle.
module tb_noc_credit_link;

    localparam int FW = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Two-stage link, 2 VCs, 4 credits.
    logic          link_en, in_valid;
    logic [0:0]    in_vc;
    logic [FW-1:0] in_flit;
    logic [1:0]    in_vc_ready;
    logic          out_valid;
    logic [0:0]    out_vc;
    logic [FW-1:0] out_flit;
    logic [1:0]    out_credit;
    logic [5:0]    credit_cnt;
    logic          err_overflow, err_credit;

    noc_credit_link #(.FLIT_WIDTH(FW), .VC_NUM(2), .LINK_STAGES(2), .CREDIT_DEPTH(4)) dut (
        .noc_clk(clk), .noc_rst(rst), .link_en(link_en),
        .in_valid(in_valid), .in_vc(in_vc), .in_flit(in_flit), .in_vc_ready(in_vc_ready),
        .out_valid(out_valid), .out_vc(out_vc), .out_flit(out_flit),
        .out_credit(out_credit), .credit_cnt(credit_cnt),
        .err_overflow(err_overflow), .err_credit(err_credit)
    );

    // Zero-stage link, 1 VC, 1 credit.
    logic       z_in_valid;
    logic [0:0] z_in_vc;
    logic [7:0] z_in_flit;
    logic [0:0] z_in_vc_ready;
    logic       z_out_valid;
    logic [0:0] z_out_vc;
    logic [7:0] z_out_flit;
    logic [0:0] z_out_credit;
    logic [0:0] z_credit_cnt;
    logic       z_err_overflow, z_err_credit;

    noc_credit_link #(.FLIT_WIDTH(8), .VC_NUM(1), .LINK_STAGES(0), .CREDIT_DEPTH(1)) dut_z (
        .noc_clk(clk), .noc_rst(rst), .link_en(1'b1),
        .in_valid(z_in_valid), .in_vc(z_in_vc), .in_flit(z_in_flit), .in_vc_ready(z_in_vc_ready),
        .out_valid(z_out_valid), .out_vc(z_out_vc), .out_flit(z_out_flit),
        .out_credit(z_out_credit), .credit_cnt(z_credit_cnt),
        .err_overflow(z_err_overflow), .err_credit(z_err_credit)
    );

    int checks   = 0;
    int failures = 0;
    logic [FW:0] exp_q[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic vc, input logic [FW-1:0] flit);
        exp_q.push_back({vc, flit});
    endtask

    // Monitor: every delivered flit must match the oldest expected one.
    logic [FW:0] m_exp;
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_flit actual=%0h expected=none at %0t", {out_vc, out_flit}, $time);
            end else begin
                m_exp = exp_q.pop_front();
                check("fwd_flit", {out_vc, out_flit}, m_exp);
            end
        end
    end

    logic prev_v;

    initial begin
        rst = 1'b1; link_en = 1'b1; in_valid = 1'b0; in_vc = '0; in_flit = '0; out_credit = '0;
        z_in_valid = 1'b0; z_in_vc = '0; z_in_flit = '0; z_out_credit = '0;
        repeat (2) step();
        @(negedge clk);
        check("rst_cnt", credit_cnt, 6'b100_100);
        check("rst_ready", in_vc_ready, 2'b11);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_vc", out_vc, 1'b0);
        check("rst_out_flit", out_flit, 64'h0);
        check("rst_errs", {err_overflow, err_credit}, 2'b00);
        check("rst_z_cnt", z_credit_cnt, 1'b1);
        step(); rst = 1'b0;

        // Reset and first send: visible two cycles later.
        step(); in_valid = 1'b1; in_vc = 1'b0; in_flit = 64'hA5; push(1'b0, 64'hA5);
        step(); in_valid = 1'b0;
        @(negedge clk);
        check("first_cnt0", credit_cnt[2:0], 3'd3);
        check("first_not_early", out_valid, 1'b0);
        step();
        @(negedge clk);
        check("first_latency", out_valid, 1'b1);

        // Credit exhaustion on VC1.
        for (int i = 0; i < 4; i++) begin
            step(); in_valid = 1'b1; in_vc = 1'b1; in_flit = 64'(16 + i); push(1'b1, 64'(16 + i));
        end
        step(); in_flit = 64'hDEAD;
        @(negedge clk);
        check("exhaust_ready1", in_vc_ready[1], 1'b0);
        check("exhaust_cnt1", credit_cnt[5:3], 3'd0);
        step(); in_valid = 1'b0;
        @(negedge clk);
        check("exhaust_err_overflow", err_overflow, 1'b1);
        check("exhaust_cnt1_hold", credit_cnt[5:3], 3'd0);
        check("exhaust_no_err_credit", err_credit, 1'b0);

        // Credit return: pulse in t, count visible at t+3.
        step(); out_credit = 2'b10;
        step(); out_credit = 2'b00;
        step();
        @(negedge clk);
        check("ret_not_early", credit_cnt[5:3], 3'd0);
        step();
        @(negedge clk);
        check("ret_cnt1", credit_cnt[5:3], 3'd1);
        check("ret_ready1", in_vc_ready[1], 1'b1);

        // Simultaneous send and credit arrival on VC0 (cnt0 goes 3 -> 2 first).
        step(); in_valid = 1'b1; in_vc = 1'b0; in_flit = 64'h22; push(1'b0, 64'h22);
        step(); in_valid = 1'b0; out_credit = 2'b01;
        step(); out_credit = 2'b00;
        step(); in_valid = 1'b1; in_vc = 1'b0; in_flit = 64'h33; push(1'b0, 64'h33);
        @(negedge clk);
        check("simul_before", credit_cnt[2:0], 3'd2);
        step(); in_valid = 1'b0;
        @(negedge clk);
        check("simul_after", credit_cnt[2:0], 3'd2);

        // Refill VC0 to 4, then one surplus credit.
        step(); out_credit = 2'b01;
        step(); out_credit = 2'b01;
        step(); out_credit = 2'b00;
        repeat (3) step();
        @(negedge clk);
        check("refill_cnt0", credit_cnt[2:0], 3'd4);
        check("refill_no_err", err_credit, 1'b0);
        step(); out_credit = 2'b01;
        step(); out_credit = 2'b00;
        step();
        step();
        @(negedge clk);
        check("surplus_err_credit", err_credit, 1'b1);
        check("surplus_cnt0", credit_cnt[2:0], 3'd4);

        // Link disable with two flits in flight.
        step(); in_valid = 1'b1; in_vc = 1'b0; in_flit = 64'h60; push(1'b0, 64'h60);
        step(); in_vc = 1'b1; in_flit = 64'h61; push(1'b1, 64'h61);
        step(); link_en = 1'b0; in_vc = 1'b0; in_flit = 64'hBAD;
        @(negedge clk);
        check("dis_ready_a", in_vc_ready, 2'b00);
        check("dis_drain_a", out_valid, 1'b1);
        step(); in_valid = 1'b0;
        @(negedge clk);
        check("dis_ready_b", in_vc_ready, 2'b00);
        check("dis_drain_b", out_valid, 1'b1);
        step();
        @(negedge clk);
        check("dis_blocked", out_valid, 1'b0);
        check("dis_drained", exp_q.size(), 0);
        step(); link_en = 1'b1;
        @(negedge clk);
        check("reen_ready", in_vc_ready, 2'b01);

        // Reset with one flit in flight.
        step(); in_valid = 1'b1; in_vc = 1'b0; in_flit = 64'h77;
        step(); in_valid = 1'b0; rst = 1'b1;
        step(); rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_cnt", credit_cnt, 6'b100_100);
        check("midrst_errs", {err_overflow, err_credit}, 2'b00);
        check("midrst_ready", in_vc_ready, 2'b11);
        step();
        @(negedge clk);
        check("midrst_dropped", out_valid, 1'b0);

        // Zero-stage link: downstream frees the slot the cycle after delivery.
        prev_v = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            z_out_credit = prev_v;
            z_in_valid   = z_in_vc_ready[0];
            z_in_flit    = 8'(8'hC0 + i);
            @(negedge clk);
            check("zero_valid", z_out_valid, (i % 2 == 0));
            check("zero_cnt", z_credit_cnt, (i % 2 == 0));
            if (i % 2 == 0) check("zero_flit", z_out_flit, 8'(8'hC0 + i));
            prev_v = z_out_valid;
        end
        step(); z_in_valid = 1'b0; z_out_credit = prev_v;
        step(); z_out_credit = 1'b0;
        @(negedge clk);
        check("zero_errs", {z_err_overflow, z_err_credit}, 2'b00);
        check("zero_cnt_end", z_credit_cnt, 1'b1);

        check("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/noc_credit_link.md
# noc_credit_link

Parametrised, credit-based, pipelined inter-router link for the mesh fabric. It replaces the direct valid/ready wiring between neighbouring router ports so that long mesh wires can be registered without breaking flow control. It carries the per-VC flit stream through `LINK_STAGES` register slices and returns per-VC credits over a matching backward pipeline. It also owns the upstream credit counters, a link-enable gate and sticky protocol-error flags.

## Interface
Parameters:
- `FLIT_WIDTH`, 64: flit payload width.
- `VC_NUM`, 2: number of virtual channels, 1..8. `VCW` = max(1, $clog2(`VC_NUM`)).
- `LINK_STAGES`, 1: register slices per direction, 0..4. A value of 0 means a combinational link.
- `CREDIT_DEPTH`, 4: downstream buffer slots per VC, 1..15. `CW` = $clog2(`CREDIT_DEPTH`+1).

Ports:
- `noc_clk`  in  1  single clock for the whole block.
- `noc_rst`  in  1  synchronous, active-high reset.
- `link_en`  in  1  0 blocks new injections; flits and credits already in flight still complete.
- `in_valid`  in  1  upstream flit valid.
- `in_vc`  in  `VCW`  VC of the upstream flit.
- `in_flit`  in  `FLIT_WIDTH`  upstream payload.
- `in_vc_ready`  out  `VC_NUM`  per-VC credit available to upstream.
- `out_valid`  out  1  downstream flit valid.
- `out_vc`  out  `VCW`  VC of the downstream flit.
- `out_flit`  out  `FLIT_WIDTH`  downstream payload.
- `out_credit`  in  `VC_NUM`  one-cycle pulse per VC when the downstream frees one slot.
- `credit_cnt`  out  `VC_NUM`*`CW`  packed credit counters, VC0 in the LSBs (debug).
- `err_overflow`  out  1  sticky: a flit was sent on a VC with 0 credits.
- `err_credit`  out  1  sticky: a credit was returned to a VC already at `CREDIT_DEPTH`.

## Operation
- **Credit counters.** There is one counter per VC, reset to `CREDIT_DEPTH`.
  - `in_vc_ready[v]` = `link_en` && `cnt[v]` != 0. It is combinational from the registers and `link_en`.
  - A send on VC v is `in_valid` && `in_vc`==v && `cnt[v]`!=0 && `link_en`. It decrements `cnt[v]` at the edge.
  - A credit arrival on VC v is `cred_ret[v]`, the output of the backward pipe. It increments `cnt[v]` at the edge.
  - A send and a credit arrival on the same VC in the same cycle leave the count unchanged.
  - Saturation, no wrap: a credit arriving at `CREDIT_DEPTH` is dropped and sets `err_credit`.
- **Illegal send.** `in_valid` on a VC with 0 credits, or `in_valid` while `link_en`=0:
  - the flit is discarded and not forwarded;
  - the counter is unchanged;
  - `err_overflow` is set.
- **Out-of-range VC.** An `in_vc` ≥ `VC_NUM` is treated as an illegal send.
- **Forward pipe.**
  - There are `LINK_STAGES` slices of {valid, vc, flit}.
  - Only accepted sends enter it with valid=1.
  - Payload registers load only when the incoming valid=1, so idle cycles hold the old data.
  - `out_valid` reflects the last stage's valid.
- **Backward pipe.**
  - There are `LINK_STAGES` slices of `VC_NUM`-bit credit vectors.
  - No merging or loss: every `out_credit` pulse produces exactly one increment.
- **Error flags.** Both flags clear only on `noc_rst`.

## Timing
- **Reset values.** A reset asserted at an edge gives:
  - all counters = `CREDIT_DEPTH`;
  - all pipe valids and credit bits = 0;
  - `out_valid`=0, `out_vc`=0, `out_flit`=0;
  - both error flags = 0.
  - `in_vc_ready` then equals {`VC_NUM`{`link_en`}}.
- **Reset mid-operation.** In-flight flits and credits are dropped. The downstream router shares `noc_rst` and is reset in the same cycle.
- **Flit latency.** A flit accepted in cycle t appears on `out_*` in cycle t+`LINK_STAGES`. With `LINK_STAGES`=0 this is the same cycle, combinationally.
- **Credit latency.**
  - An `out_credit` pulse in cycle t raises `cnt` visibly in cycle t+`LINK_STAGES`+1.
  - With `LINK_STAGES`=0 the pulse is used directly and the count rises in cycle t+1.
- **Throughput.** One flit per cycle per link.
- **Round trip.** A VC sustains full rate only if `CREDIT_DEPTH` ≥ 2·`LINK_STAGES`+1+(downstream pop latency). Below that, bubbles are expected and are not an error.
- **`link_en` fall.** When `link_en` falls in cycle t:
  - `in_vc_ready` goes to 0 in cycle t;
  - injections stop in cycle t;
  - the pipes drain within `LINK_STAGES` cycles;
  - credits still return and counters recover to `CREDIT_DEPTH` once downstream drains.

## Test plan
- **Reset and first send.** `LINK_STAGES`=2, `CREDIT_DEPTH`=4. Reset, then send VC0 flit 0xA5 in cycle 0 -> `out_valid`=1, `out_vc`=0, `out_flit`=0xA5 in cycle 2. `cnt[0]`=3 from cycle 1.
- **Credit exhaustion.** Send 4 back-to-back flits on VC1 with no credits returned -> `in_vc_ready[1]`=0 after the 4th. A 5th `in_valid` on VC1 is not forwarded, `err_overflow`=1, `cnt[1]` stays 0.
- **Credit return.** After exhaustion, pulse `out_credit[1]` in cycle t -> `in_vc_ready[1]`=1 and `cnt[1]`=1 in cycle t+3.
- **Simultaneous send and credit.** With `cnt[0]`=2, a VC0 send coincides with VC0 credit arrival -> `cnt[0]` stays 2. A credit pulse on VC0 while `cnt[0]`=4 -> `err_credit`=1, `cnt[0]`=4.
- **Zero-stage link.** `LINK_STAGES`=0, `CREDIT_DEPTH`=1, downstream returning a credit each accepted cycle -> `out_valid` is asserted in the same cycle as the send. Credits go 1→0→1 and the link sustains one flit every 2 cycles.
- **Link disable and reset mid-flight.** With 2 flits in flight, drop `link_en` -> both flits delivered, `in_vc_ready`=0 throughout. Then reset with 1 flit in flight -> `out_valid`=0 next cycle and all counters = 4.
